// File: rtl/fetch_unit.sv
// Instruction-fetch sequencer: latches PC, holds an imem read until ack, returns the word with a 1-cycle iready.
// Latency: 3 cycles per instruction plus memory wait states; stall holds off new fetches only, never an issued request.
module fetch_unit #(
  parameter int          TIMEOUT = 255,
  parameter logic [31:0] NOP     = 32'h00000013
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic [31:0] PCaddr,
  input  logic        stall,
  output logic        imem_ren,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic        iready,
  output logic [31:0] instr,
  output logic        fetch_err
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;
  localparam logic [1:0] ERR   = 2'd3;

  logic [1:0]    state;
  logic [TW-1:0] timer;

  always_ff @(posedge clk) begin
    if (!nRST) begin
      state     <= IDLE;
      imem_ren  <= 1'b0;
      imem_addr <= 32'd0;
      iready    <= 1'b0;
      instr     <= NOP;
      fetch_err <= 1'b0;
      timer     <= '0;
    end else begin
      case (state)
        IDLE: begin
          iready <= 1'b0;
          if (!stall) begin
            state     <= FETCH;
            imem_addr <= PCaddr;
            imem_ren  <= 1'b1;
            timer     <= '0;
          end
        end
        FETCH: begin
          // ack takes priority over a timeout landing in the same cycle
          if (imem_ack) begin
            instr    <= imem_rdata;
            iready   <= 1'b1;
            imem_ren <= 1'b0;
            state    <= DONE;
          end else if (timer == TIMER_LAST) begin
            fetch_err <= 1'b1;
            imem_ren  <= 1'b0;
            state     <= ERR;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DONE: begin
          iready <= 1'b0;
          state  <= IDLE;
        end
        ERR: begin
          imem_ren <= 1'b0;
          iready   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
